comparator_32_bit: RTL and testbench

- Registered 32-bit unsigned magnitude comparator producing one-hot EQ/GT/LT flags.
- Used as an area-efficient compare primitive in datapath and control logic.
- Built hierarchically from 4-bit compare cells merged MSB-first.
- Behaviour is exact; no approximation is permitted in this block.

---
 rtl/comparator_pkg.sv | 27 ++
 rtl/comparator_4_bit.sv | 24 ++
 rtl/comparator_32_bit.sv | 90 +++++++++
 tb/tb_comparator_32_bit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared types and helpers for the hierarchical unsigned magnitude comparator.
package comparator_pkg;

  localparam int unsigned CMP_WIDTH  = 32;
  localparam int unsigned CMP_CELL_W = 4;
  localparam int unsigned CMP_NCELLS = CMP_WIDTH / CMP_CELL_W;

  // One-hot compare outcome; all-zero means "no result yet".
  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_res_t;

  localparam cmp_res_t CMP_RES_NONE = '{eq: 1'b0, gt: 1'b0, lt: 1'b0};

  // Combine the result of a more-significant slice (hi) with a less-significant one (lo).
  // The high slice decides unless it is equal, in which case the low slice decides.
  function automatic cmp_res_t cmp_merge(cmp_res_t hi, cmp_res_t lo);
    cmp_res_t r;
    r.eq = hi.eq & lo.eq;
    r.gt = hi.gt | (hi.eq & lo.gt);
    r.lt = hi.lt | (hi.eq & lo.lt);
    return r;
  endfunction

endpackage

// File: rtl/comparator_4_bit.sv
// Combinational leaf compare cell: unsigned nibble compare with a one-hot result.
module comparator_4_bit
  import comparator_pkg::*;
#(
  parameter int unsigned CellW = CMP_CELL_W
) (
  input  logic [CellW-1:0] a_i,
  input  logic [CellW-1:0] b_i,
  output cmp_res_t         res_o
);

  // Exactly one flag set for any known pair of inputs.
  always_comb begin
    res_o = CMP_RES_NONE;
    if (a_i == b_i) begin
      res_o.eq = 1'b1;
    end else if (a_i > b_i) begin
      res_o.gt = 1'b1;
    end else begin
      res_o.lt = 1'b1;
    end
  end

endmodule

// File: rtl/comparator_32_bit.sv
// Registered unsigned magnitude comparator built from nibble cells merged MSB-first.
// EQ/GT/LT are one-hot one cycle after A/B are sampled; all zero during/after reset.
module comparator_32_bit
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH      = CMP_WIDTH,
  parameter int unsigned CELL_W     = CMP_CELL_W,
  // 1: balanced pairwise tree, 0: linear chain. Both give identical results.
  parameter bit          TREE_MERGE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             EQ,
  output logic             GT,
  output logic             LT
);

  // WIDTH is expected to be a whole number of cells.
  localparam int unsigned NCells  = WIDTH / CELL_W;
  localparam int unsigned NLevels = (NCells > 1) ? $clog2(NCells) : 1;

  cmp_res_t cell_res [NCells];
  cmp_res_t merged;
  cmp_res_t res_d, res_q;

  // Leaf cells: cell i covers bits [CELL_W*i +: CELL_W]; cell NCells-1 holds the MSBs.
  for (genvar gi = 0; gi < NCells; gi++) begin : g_cell
    comparator_4_bit #(
      .CellW (CELL_W)
    ) u_cell (
      .a_i   (A[gi*CELL_W +: CELL_W]),
      .b_i   (B[gi*CELL_W +: CELL_W]),
      .res_o (cell_res[gi])
    );
  end

  if (TREE_MERGE) begin : g_tree
    // Pairwise reduction: each level merges neighbours (odd index is the higher slice);
    // an unpaired top entry is passed up unchanged.
    always_comb begin
      cmp_res_t lvl [NCells];
      int unsigned n;
      for (int i = 0; i < NCells; i++) begin
        lvl[i] = cell_res[i];
      end
      n = NCells;
      for (int l = 0; l < NLevels; l++) begin
        for (int j = 0; j < NCells / 2; j++) begin
          if (j < n / 2) begin
            lvl[j] = cmp_merge(lvl[2*j+1], lvl[2*j]);
          end
        end
        if ((n % 2) == 1 && n > 1) begin
          lvl[n/2] = lvl[n-1];
        end
        n = (n + 1) / 2;
      end
      merged = lvl[0];
    end
  end else begin : g_chain
    // Linear chain from the MSB cell down to the LSB cell.
    always_comb begin
      merged = cell_res[NCells-1];
      for (int i = NCells - 2; i >= 0; i--) begin
        merged = cmp_merge(merged, cell_res[i]);
      end
    end
  end

  // Next result is simply the merged compare of the current inputs.
  always_comb begin
    res_d = merged;
  end

  // Result register; synchronous reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= CMP_RES_NONE;
    end else begin
      res_q <= res_d;
    end
  end

  assign EQ = res_q.eq;
  assign GT = res_q.gt;
  assign LT = res_q.lt;

endmodule

// File: tb/tb_comparator_32_bit.sv
// Self-checking bench for comparator_32_bit: directed vectors, latency, mid-stream reset
// and randomized pairs against an arithmetic reference compare.
module tb_comparator_32_bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a   = '0;
  logic [31:0] b   = '0;
  logic        eq, gt, lt;

  int tests_run = 0;
  int fails     = 0;

  comparator_32_bit dut (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .B   (b),
    .EQ  (eq),
    .GT  (gt),
    .LT  (lt)
  );

  always #5 clk = ~clk;

  // Reference: {EQ,GT,LT} from plain unsigned arithmetic.
  function automatic logic [2:0] ref_cmp(logic [31:0] x, logic [31:0] y);
    if (x == y) return 3'b100;
    if (x > y)  return 3'b010;
    return 3'b001;
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] got;
    rst = 1'b1; a = '0; b = '0;
    tick();
    tick();
    got = {eq, gt, lt};
    tests_run++;
    if (got !== 3'b000) begin
      fails++;
      $display("FAIL reset_hold: got %b want 000", got);
    end
    rst = 1'b0;
    tick();
    got = {eq, gt, lt};
    tests_run++;
    if (got !== 3'b100) begin
      fails++;
      $display("FAIL reset_first_result: got %b want 100", got);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [18];
    logic [31:0] vb [18];
    logic [2:0]  ve [18];
    logic [2:0]  got;
    va = '{32'h00000008, 32'h80000000, 32'hC0000008, 32'h80000008, 32'h80000008,
           32'h80000008, 32'hB3849008, 32'h98000808, 32'h80000008, 32'h80000008,
           32'hF2090808, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000000, 32'h00000000,
           32'h00000001, 32'h80000000, 32'h7FFFFFFF};
    vb = '{32'h80000000, 32'h00000008, 32'h80008000, 32'h80008000, 32'h80B00000,
           32'h8D000000, 32'h82090000, 32'h82000000, 32'hE0000000, 32'h80000008,
           32'hF2090808, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF,
           32'h00000000, 32'h7FFFFFFF, 32'h80000000};
    ve = '{3'b001, 3'b010, 3'b010, 3'b001, 3'b001,
           3'b001, 3'b010, 3'b010, 3'b001, 3'b100,
           3'b100, 3'b100, 3'b001, 3'b100, 3'b001,
           3'b010, 3'b010, 3'b001};
    for (int i = 0; i < 18; i++) begin
      a = va[i]; b = vb[i];
      tick();
      got = {eq, gt, lt};
      tests_run++;
      if (got !== ve[i]) begin
        fails++;
        $display("FAIL directed[%0d] A=%h B=%h: got %b want %b", i, va[i], vb[i], got, ve[i]);
      end
    end
  endtask

  // New pair every cycle; each result must belong to the pair sampled at that edge.
  task automatic test_back_to_back();
    logic [2:0] got, exp;
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? a : $urandom;
      exp = ref_cmp(a, b);
      tick();
      got = {eq, gt, lt};
      tests_run++;
      if (got !== exp) begin
        fails++;
        $display("FAIL back_to_back[%0d] A=%h B=%h: got %b want %b", i, a, b, got, exp);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [2:0] got, exp;
    a = 32'h00000005; b = 32'h00000003;
    tick();
    rst = 1'b1; a = 32'h00000001; b = 32'h00000002;
    tick();
    got = {eq, gt, lt};
    tests_run++;
    if (got !== 3'b000) begin
      fails++;
      $display("FAIL midstream_reset_clear: got %b want 000", got);
    end
    rst = 1'b0; a = 32'h12345678; b = 32'h12345679;
    exp = ref_cmp(a, b);
    tick();
    got = {eq, gt, lt};
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL midstream_reset_resume: got %b want %b", got, exp);
    end
  endtask

  task automatic test_random();
    logic [2:0] got, exp;
    for (int i = 0; i < 10000; i++) begin
      a = $urandom;
      case (i % 4)
        0:       b = a;
        1:       b = a ^ (32'h1 << $urandom_range(31, 0));
        default: b = $urandom;
      endcase
      exp = ref_cmp(a, b);
      tick();
      got = {eq, gt, lt};
      tests_run++;
      if (got !== exp || !$onehot(got)) begin
        fails++;
        $display("FAIL random[%0d] A=%h B=%h: got %b want %b", i, a, b, got, exp);
      end
    end
  endtask

  // Every single-bit difference position, with random surrounding bits.
  task automatic test_single_bit();
    logic [2:0] got, exp;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 32; k++) begin
        a = $urandom;
        b = a ^ (32'h1 << k);
        exp = a[k] ? 3'b010 : 3'b001;
        tick();
        got = {eq, gt, lt};
        tests_run++;
        if (got !== exp) begin
          fails++;
          $display("FAIL single_bit[%0d] A=%h B=%h: got %b want %b", k, a, b, got, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_midstream_reset();
    test_random();
    test_single_bit();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
